// File: rtl/wide_add_sequencer.sv
// Multi-cycle LSW-first slice sequencer for a combinational WIDTH-bit adder.
// Define WIDE_ADD_SUB_EN to add the op_sub port (two's-complement subtract).
module wide_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*WIDTH-1:0] op_a,
  input  logic [WORDS*WIDTH-1:0] op_b,
  input  logic                   op_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                   op_sub,
`endif
  output logic [WIDTH-1:0]       add_A,
  output logic [WIDTH-1:0]       add_B,
  output logic                   add_Cin,
  output logic                   add_EN,
  input  logic [WIDTH-1:0]       add_Sum,
  input  logic                   add_Cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*WIDTH-1:0] result,
  output logic                   result_cout
);

  localparam int OW = WORDS * WIDTH;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   a_q, a_d;
  logic [OW-1:0]   b_q, b_d;
  logic [OW-1:0]   res_q, res_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            sub_now;
  logic            acc_sub;
  logic [OW+WIDTH-1:0] res_cat;
  logic [WIDTH-1:0]    b_slice;

`ifdef WIDE_ADD_SUB_EN
  logic sub_q, sub_d;
  assign sub_now = sub_q;
  assign acc_sub = op_sub;
`else
  assign sub_now = 1'b0;
  assign acc_sub = 1'b0;
`endif

  // New Sum slice enters at the top; after WORDS shifts it sits LSW-aligned
  assign res_cat = {add_Sum, res_q};
  assign b_slice = sub_now ? ~b_q[WIDTH-1:0] : b_q[WIDTH-1:0];

  assign in_ready    = (state_q == IDLE);
  assign add_EN      = (state_q == RUN);
  assign out_valid   = (state_q == DONE);
  assign add_A       = add_EN ? a_q[WIDTH-1:0] : '0;
  assign add_B       = add_EN ? b_slice : '0;
  assign add_Cin     = add_EN ? carry_q : 1'b0;
  assign result      = res_q;
  assign result_cout = cout_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef WIDE_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = acc_sub ? 1'b1 : op_cin;
          idx_d   = '0;
`ifdef WIDE_ADD_SUB_EN
          sub_d   = op_sub;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_cat[OW+WIDTH-1:WIDTH];
        carry_d = add_Cout;
        a_d     = a_q >> WIDTH;
        b_d     = b_q >> WIDTH;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_Cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef WIDE_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef WIDE_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer with a behavioural adder slice.
module tb_wide_add_sequencer;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int OW = W * N;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] op_a = '0;
  logic [OW-1:0] op_b = '0;
  logic          op_cin = 1'b0;
  logic          op_sub = 1'b0;
  logic [W-1:0]  add_A, add_B, add_Sum;
  logic          add_Cin, add_EN, add_Cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] result;
  logic          result_cout;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign {add_Cout, add_Sum} = add_EN ?
    (17'(add_A) + 17'(add_B) + 17'(add_Cin)) : 17'd0;

  wide_add_sequencer #(.WIDTH(W), .WORDS(N)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
`ifdef WIDE_ADD_SUB_EN
    .op_sub      (op_sub),
`endif
    .add_A       (add_A),
    .add_B       (add_B),
    .add_Cin     (add_Cin),
    .add_EN      (add_EN),
    .add_Sum     (add_Sum),
    .add_Cout    (add_Cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_cout (result_cout)
  );

  task automatic chk(input string tag, input logic [OW:0] obs,
                     input logic [OW:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: full-width arithmetic; carry into slice i from low-part sums
  task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [OW:0]   exp;
    logic [OW-1:0] al, bl, mask;
    logic          ec;
    int            k;
    if (sub) exp = {a >= b, a - b};
    else     exp = {1'b0, a} + {1'b0, b} + (OW+1)'(cin);
    @(negedge CLK);
    chk("idle_ready", in_ready, 1);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge CLK);
    in_valid = 1'b0;
    op_a = rnd64(); op_b = rnd64(); op_cin = 1'($urandom);
    op_sub = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      k = W * i;
      mask = (i == 0) ? '0 : ((OW'(1) << k) - 1);
      al = a & mask;
      bl = b & mask;
      if (sub) ec = (al >= bl);
      else     ec = 1'(((OW+1)'(al) + (OW+1)'(bl) + (OW+1)'(cin)) >> k);
      chk("run_en", add_EN, 1);
      chk("run_ready", in_ready, 0);
      chk("run_ovalid", out_valid, 0);
      chk("run_cin", add_Cin, ec);
      chk("run_a", add_A, a[k+:W]);
      @(negedge CLK);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op_a = rnd64(); op_b = rnd64();
      chk("hold_ovalid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_res", {result_cout, result}, exp);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    chk("done_ovalid", out_valid, 1);
    chk("done_res", {result_cout, result}, exp);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk("post_ovalid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_en", add_EN, 0);
    chk("post_res", {result_cout, result}, exp);
  endtask

  initial begin
    logic s;
    // Reset with random inputs applied
    RST = 1'b1;
    repeat (2) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      op_a = rnd64(); op_b = rnd64(); op_cin = 1'($urandom);
      @(negedge CLK);
    end
    chk("rst_ready", in_ready, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_en", add_EN, 0);
    chk("rst_res", {result_cout, result}, 0);
    chk("rst_add", {add_A, add_B, add_Cin}, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    RST = 1'b0;

    run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
    run_op(rnd64(), rnd64(), 1'b0, 1'b0, 3);

    // Reset pulse in the second RUN cycle aborts the operation
    @(negedge CLK);
    op_a = rnd64(); op_b = rnd64(); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("abort_run0", add_EN, 1);
    @(negedge CLK);
    chk("abort_run1", add_EN, 1);
    RST = 1'b1;
    #1;
    chk("abort_en", add_EN, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      chk("abort_noval", out_valid, 0);
      @(negedge CLK);
    end
    out_ready = 1'b0;
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 0);

`ifdef WIDE_ADD_SUB_EN
    run_op(64'h10, 64'h20, 1'b0, 1'b1, 0);
    run_op(64'h20, 64'h10, 1'b1, 1'b1, 1);
`endif

    for (int t = 0; t < 24; t++) begin
`ifdef WIDE_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op(rnd64(), rnd64(), 1'($urandom), s, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
